// File: rtl/shot_mover.sv
// -----------------------------------------------------------------------------
// shot_mover
//
// This block moves a single projectile ("shot") up the screen. It also
// produces the per-pixel box information that the bitmap stage uses to draw
// the sprite.
//
// Shot life cycle:
//   IDLE      Waits for fire. When fire is accepted, the launch position is
//             latched. The X position is clamped so the sprite stays on screen.
//   FLYING    The shot moves up by SPEED_Y pixels on every startOfFrame.
//             The flight ends on a collision, or when the next step would
//             move the shot above row 0.
//   COOLDOWN  Dead time of COOLDOWN_FRAMES frames before the next shot can
//             be fired. This state is only used when SHOT_COOLDOWN_EN is
//             defined.
//
// Configuration macro:
//   SHOT_COOLDOWN_EN
//     Defined:   a finished shot goes through COOLDOWN, timed by an 8-bit
//                frame counter.
//     Undefined: a finished shot returns directly to IDLE, and
//                COOLDOWN_FRAMES has no effect.
//
// Ports:
//   clk              in   system clock; all logic runs on the rising edge
//   resetN           in   synchronous active-low reset
//   startOfFrame     in   one-cycle pulse per video frame
//   pixelX/pixelY    in   current scan position (11 bits each)
//   fire             in   launch request (level, sampled every cycle)
//   launchX/launchY  in   requested top-left position of the shot at launch
//   collision        in   the shot hit something; ends the flight
//   offsetX/offsetY  out  scan pixel minus shot top-left; 0 when outside the box
//   InsideRectangle  out  scan pixel lies inside the flying shot's box
//   shotActive       out  high while the state is FLYING
//   fireAck          out  one-cycle pulse when a fire request is accepted
// -----------------------------------------------------------------------------
module shot_mover #(
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 16,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SPEED_Y         = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        fire,
    input  logic [10:0] launchX,
    input  logic [10:0] launchY,
    input  logic        collision,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        shotActive,
    output logic        fireAck
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Largest top-left X that still keeps the whole sprite on screen.
    localparam logic [11:0] MAX_X    = 12'(SCREEN_WIDTH - OBJECT_WIDTH_X);
    localparam logic [11:0] WIDTH12  = 12'(OBJECT_WIDTH_X);
    localparam logic [11:0] HEIGHT12 = 12'(OBJECT_HEIGHT_Y);
    localparam logic [11:0] SPEED12  = 12'(SPEED_Y);
    localparam logic [10:0] SPEED11  = 11'(SPEED_Y);

    state_t      state;
    logic [10:0] top_left_x;
    logic [10:0] top_left_y;

`ifdef SHOT_COOLDOWN_EN
    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);
    logic [7:0] cooldown_cnt;
`else
    // Without the cooldown feature, COOLDOWN_FRAMES is not used.
    // This signal only absorbs it so the parameter is still referenced.
    logic unused_cooldown_cfg;
    assign unused_cooldown_cfg = ^8'(COOLDOWN_FRAMES);
`endif

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------

    // All box comparisons are widened to 12 bits. This keeps
    // top_left + size from wrapping near the 11-bit limit.
    logic [11:0] px12;
    logic [11:0] py12;
    logic [11:0] tlx12;
    logic [11:0] tly12;
    logic        inside_x;
    logic        inside_y;
    logic [10:0] launch_x_clamped;
    logic        y_would_underflow;
    logic        shot_end;

    assign px12  = {1'b0, pixelX};
    assign py12  = {1'b0, pixelY};
    assign tlx12 = {1'b0, top_left_x};
    assign tly12 = {1'b0, top_left_y};

    assign inside_x = (px12 >= tlx12) && (px12 < tlx12 + WIDTH12);
    assign inside_y = (py12 >= tly12) && (py12 < tly12 + HEIGHT12);

    assign launch_x_clamped = ({1'b0, launchX} > MAX_X) ? MAX_X[10:0] : launchX;

    // Another step would move the shot above row 0. The flight ends here
    // instead of storing a wrapped (underflowed) Y position.
    assign y_would_underflow = (tly12 < SPEED12);

    // Collision has priority over movement. Either event ends the flight.
    assign shot_end = (state == FLYING) &&
                      (collision || (startOfFrame && y_would_underflow));

    // ---------------------------------------------------------------------
    // State, position and registered outputs
    // ---------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments. Every
    // right-hand side therefore sees the value from before this edge.
    // Because of this, the box compare below uses the top-left position
    // from before any movement that happens in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state           <= IDLE;
            top_left_x      <= '0;
            top_left_y      <= '0;
`ifdef SHOT_COOLDOWN_EN
            cooldown_cnt    <= '0;
`endif
            offsetX         <= '0;
            offsetY         <= '0;
            InsideRectangle <= 1'b0;
            shotActive      <= 1'b0;
            fireAck         <= 1'b0;
        end else begin
            // Box outputs: one cycle of latency from pixelX/pixelY.
            if ((state == FLYING) && inside_x && inside_y) begin
                InsideRectangle <= 1'b1;
                offsetX         <= pixelX - top_left_x;
                offsetY         <= pixelY - top_left_y;
            end else begin
                InsideRectangle <= 1'b0;
                offsetX         <= '0;
                offsetY         <= '0;
            end

            fireAck <= 1'b0;

            case (state)
                IDLE: begin
                    if (fire) begin
                        top_left_x <= launch_x_clamped;
                        top_left_y <= launchY;
                        fireAck    <= 1'b1;
                        shotActive <= 1'b1;
                        state      <= FLYING;
                    end
                end

                FLYING: begin
                    if (shot_end) begin
                        shotActive <= 1'b0;
`ifdef SHOT_COOLDOWN_EN
                        cooldown_cnt <= COOLDOWN_LOAD;
                        state        <= COOLDOWN;
`else
                        state        <= IDLE;
`endif
                    end else if (startOfFrame) begin
                        top_left_y <= top_left_y - SPEED11;
                    end
                end

                COOLDOWN: begin
`ifdef SHOT_COOLDOWN_EN
                    // The counter counts down to 0, one step per frame.
                    // The next startOfFrame after it reaches 0 releases
                    // the block back to IDLE.
                    if (startOfFrame) begin
                        if (cooldown_cnt == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            cooldown_cnt <= cooldown_cnt - 8'd1;
                        end
                    end
`else
                    // Cannot be reached without the cooldown feature.
                    state <= IDLE;
`endif
                end

                default: begin
                    state      <= IDLE;
                    shotActive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_mover.sv
// -----------------------------------------------------------------------------
// tb_shot_mover
//
// Directed testbench for shot_mover, using the default parameters.
// Expected values are worked out by hand from the block's behaviour.
// Inputs change 1 time unit after a rising edge. Outputs are sampled
// 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_shot_mover;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        fire;
    logic [10:0] launchX;
    logic [10:0] launchY;
    logic        collision;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        shotActive;
    logic        fireAck;

    int errors;
    int checks;

    shot_mover dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .fire            (fire),
        .launchX         (launchX),
        .launchY         (launchY),
        .collision       (collision),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .shotActive      (shotActive),
        .fireAck         (fireAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value.
    // Counts the comparison and prints a line on a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advances one clock. Returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Produces a one-cycle startOfFrame pulse followed by one idle cycle.
    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    // Moves the block from the end of a shot back to IDLE.
    // With cooldown enabled this takes nine frames.
    task automatic finish_cooldown();
`ifdef SHOT_COOLDOWN_EN
        repeat (9) frame();
`endif
    endtask

    // Launches a shot from IDLE and checks that it is accepted.
    task automatic launch(input string tag, input int x, input int y);
        launchX = 11'(x);
        launchY = 11'(y);
        fire    = 1'b1;
        step();
        fire    = 1'b0;
        check({tag, "_fireAck"}, 32'(fireAck), 32'd1);
        check({tag, "_shotActive"}, 32'(shotActive), 32'd1);
    endtask

    // Checks the registered box outputs for the pixel applied one cycle earlier.
    task automatic box(input string tag, input int x, input int y,
                       input int in_exp, input int ox_exp, input int oy_exp);
        pixelX = 11'(x);
        pixelY = 11'(y);
        step();
        check({tag, "_inside"}, 32'(InsideRectangle), 32'(in_exp));
        check({tag, "_offX"}, 32'(offsetX), 32'(ox_exp));
        check({tag, "_offY"}, 32'(offsetY), 32'(oy_exp));
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        fire         = 1'b0;
        launchX      = '0;
        launchY      = '0;
        collision    = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_fireAck", 32'(fireAck), 32'd0);
        check("rst_shotActive", 32'(shotActive), 32'd0);
        check("rst_inside", 32'(InsideRectangle), 32'd0);
        check("rst_offX", 32'(offsetX), 32'd0);
        check("rst_offY", 32'(offsetY), 32'd0);
        resetN = 1'b1;
        step();
        check("idle_shotActive", 32'(shotActive), 32'd0);

        // Basic launch at (100,400). Pixel (105,403) is inside, offset (5,3).
        launch("l1", 100, 400);
        box("l1_px", 105, 403, 1, 5, 3);
        check("l1_ack_pulse", 32'(fireAck), 32'd0);

        // fire is ignored while the shot is FLYING.
        fire = 1'b1;
        step();
        fire = 1'b0;
        check("fly_fire_ignored", 32'(fireAck), 32'd0);

        // Three frames: Y goes 400 -> 388. Check the box edges.
        repeat (3) frame();
        box("y388_above", 100, 387, 0, 0, 0);
        box("y388_top", 100, 388, 1, 0, 0);
        box("y388_right", 115, 388, 1, 15, 0);
        box("y388_pastR", 116, 388, 0, 0, 0);
        box("y388_bot", 100, 403, 1, 0, 15);
        box("y388_pastB", 100, 404, 0, 0, 0);
        box("y388_left", 99, 390, 0, 0, 0);
        check("y388_shotActive", 32'(shotActive), 32'd1);

        // A collision ends the flight.
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("coll_shotActive", 32'(shotActive), 32'd0);
        box("coll_nobox", 100, 390, 0, 0, 0);
        finish_cooldown();

        // Collision and startOfFrame in the same cycle at Y=200.
        // Collision wins. The box compare in that cycle still uses Y=200.
        launch("l2", 300, 200);
        pixelX       = 11'd300;
        pixelY       = 11'd200;
        collision    = 1'b1;
        startOfFrame = 1'b1;
        step();
        collision    = 1'b0;
        startOfFrame = 1'b0;
        check("l2_shotActive", 32'(shotActive), 32'd0);
        check("l2_preupd_inside", 32'(InsideRectangle), 32'd1);
        check("l2_preupd_offY", 32'(offsetY), 32'd0);
        box("l2_after", 300, 200, 0, 0, 0);
        finish_cooldown();

        // launchX=635 is clamped to 624.
        launch("l3", 635, 50);
        box("l3_px639", 639, 50, 1, 15, 0);
        box("l3_px624", 624, 50, 1, 0, 0);
        box("l3_px623", 623, 50, 0, 0, 0);
        collision = 1'b1;
        step();
        collision = 1'b0;
        finish_cooldown();

        // Y=2 is below SPEED_Y. The next frame ends the flight.
        launch("l4", 10, 2);
        box("l4_in", 10, 2, 1, 0, 0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("l4_end_shotActive", 32'(shotActive), 32'd0);
        pixelX = 11'd10;
        pixelY = 11'd2;
        fire   = 1'b1;
        step();
        check("l4_end_inside", 32'(InsideRectangle), 32'd0);
`ifdef SHOT_COOLDOWN_EN
        // fire is held high through the whole cooldown.
        check("cd_fireAck_0", 32'(fireAck), 32'd0);
        for (int f = 0; f < 8; f++) begin
            frame();
            check("cd_fireAck_frame", 32'(fireAck), 32'd0);
        end
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("cd_9th_fireAck", 32'(fireAck), 32'd0);
        step();
        check("cd_accept_fireAck", 32'(fireAck), 32'd1);
`else
        check("nocd_accept_fireAck", 32'(fireAck), 32'd1);
`endif
        fire = 1'b0;
        check("l5_shotActive", 32'(shotActive), 32'd1);

        // Reset for one cycle mid-flight, with fire held high.
        box("l5_in", 12, 5, 1, 2, 3);
        resetN = 1'b0;
        fire   = 1'b1;
        step();
        check("mid_rst_inside", 32'(InsideRectangle), 32'd0);
        check("mid_rst_offX", 32'(offsetX), 32'd0);
        check("mid_rst_offY", 32'(offsetY), 32'd0);
        check("mid_rst_shotActive", 32'(shotActive), 32'd0);
        check("mid_rst_fireAck", 32'(fireAck), 32'd0);
        resetN = 1'b1;
        step();
        check("rel_fireAck", 32'(fireAck), 32'd1);
        check("rel_shotActive", 32'(shotActive), 32'd1);
        step();
        check("rel_ack_pulse", 32'(fireAck), 32'd0);
        fire = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
